// File: rtl/alu_multicycle_pkg.sv
// Shared opcodes, FSM encoding and opcode helpers for the multi-cycle ALU.
// The package keeps the name alu_pkg so every file imports the same symbols.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // SUB and SLT both run the adder as a + ~b + 1.
    function automatic logic invert_b(input logic [2:0] command);
        return (command == OP_SUB) || (command == OP_SLT);
    endfunction

    // Only ADD and SUB report carryout and overflow.
    function automatic logic reports_carry(input logic [2:0] command);
        return (command == OP_ADD) || (command == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/command and result/flag channels between the ALU and its neighbours.
// Each side transfers on a rising edge where valid and ready are both high;
// valid is held with its payload until that edge, and ready may depend on state only.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       command;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, command, a, b, out_ready,
        input  in_ready, out_valid, result, carryout, overflow, zero
    );

    modport slave (
        input  in_valid, command, a, b, out_ready,
        output in_ready, out_valid, result, carryout, overflow, zero
    );
endinterface

// File: rtl/alu_multicycle_slice.sv
// Combinational SLICE-bit ALU cell: ripple chain of full adders plus per-bit logic.
// The top time-shares a single instance across all slices of an operation.
module structural_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic a_xor_b;
    logic gen;
    logic prop;

    assign a_xor_b = a ^ b;
    assign sum     = a_xor_b ^ cin;
    assign gen     = a & b;
    assign prop    = a_xor_b & cin;
    assign cout    = gen | prop;
endmodule

module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [2:0]       command,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             cin,
    output logic [SLICE-1:0] y_s,
    output logic             cout,
    output logic             c_msb_in
);
    logic [SLICE:0]   carry;
    logic [SLICE-1:0] b_eff;
    logic [SLICE-1:0] sum;

    assign b_eff    = b_s ^ {SLICE{invert_b(command)}};
    assign carry[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        structural_full_adder u_fa (
            .a    (a_s[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout     = carry[SLICE];
    // Carry into the top bit of this slice; only meaningful on the MSB slice.
    assign c_msb_in = carry[SLICE-1];

    always_comb begin
        y_s = sum;
        case (command)
            OP_XOR:  y_s = a_s ^ b_s;
            OP_NAND: y_s = ~(a_s & b_s);
            OP_NOR:  y_s = ~(a_s | b_s);
            OP_AND:  y_s = a_s & b_s;
            OP_OR:   y_s = a_s | b_s;
            default: y_s = sum;
        endcase
    end
endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: WIDTH-bit operation computed SLICE bits per clock, carry
// rippled between slices through carry_reg; results and flags held in DONE.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_multicycle_if.slave    bus,
    output state_t             fsm_state
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       cmd_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carryout_reg;
    logic             overflow_reg;
    logic             zero_reg;

    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] y_s;
    logic             slice_cout;
    logic             slice_c_msb_in;
    logic             last;
    logic             msb_overflow;
    logic [WIDTH-1:0] result_next;

    assign last         = (cnt == CW'(N - 1));
    assign a_s          = a_reg[cnt*SLICE +: SLICE];
    assign b_s          = b_reg[cnt*SLICE +: SLICE];
    assign msb_overflow = slice_c_msb_in ^ slice_cout;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .command  (cmd_reg),
        .a_s      (a_s),
        .b_s      (b_s),
        .cin      (carry_reg),
        .y_s      (y_s),
        .cout     (slice_cout),
        .c_msb_in (slice_c_msb_in)
    );

    // On the last slice the full result is known, so SLT collapses it to the sign test.
    always_comb begin
        result_next = result_reg;
        result_next[cnt*SLICE +: SLICE] = y_s;
        if (last && (cmd_reg == OP_SLT)) begin
            result_next = WIDTH'(y_s[SLICE-1] ^ msb_overflow);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            cmd_reg      <= OP_ADD;
            carry_reg    <= 1'b0;
            result_reg   <= '0;
            carryout_reg <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        cmd_reg   <= bus.command;
                        carry_reg <= invert_b(bus.command);
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= slice_cout;
                    if (last) begin
                        carryout_reg <= reports_carry(cmd_reg) & slice_cout;
                        overflow_reg <= reports_carry(cmd_reg) & msb_overflow;
                        zero_reg     <= (result_next == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = result_reg;
    assign bus.carryout = carryout_reg;
    assign bus.overflow = overflow_reg;
    assign bus.zero     = zero_reg;
    assign fsm_state    = state;
endmodule
